// File: rtl/instr_mem_loader.sv
// Assembles big-endian UART bytes into instruction words and writes them to imem.
// Ports: i_clk/i_reset_n, i_start, i_rx_data/i_rx_valid in; o_we/o_addr/o_wdata, o_busy/o_done/o_error/o_word_count out. Option: INSTR_LOADER_TIMEOUT_EN.
module instr_mem_loader #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int MEM_DEPTH = 64,
  parameter logic [31:0] HALT_WORD = 32'hFFFFFFFF,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic                         i_clk,
  input  logic                         i_reset_n,
  input  logic                         i_start,
  input  logic [7:0]                   i_rx_data,
  input  logic                         i_rx_valid,
  output logic                         o_we,
  output logic [ADDR_WIDTH-1:0]        o_addr,
  output logic [DATA_WIDTH-1:0]        o_wdata,
  output logic                         o_busy,
  output logic                         o_done,
  output logic                         o_error,
  output logic [$clog2(MEM_DEPTH):0]   o_word_count
);

  localparam int IW = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
  localparam int CW = $clog2(MEM_DEPTH) + 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RECV,
    S_WRITE,
    S_DONE,
    S_ERROR
  } state_t;

  state_t                  state;
  logic [1:0]              byte_cnt;
  logic [DATA_WIDTH-9:0]   shreg;
  logic [IW-1:0]           word_idx;

`ifdef INSTR_LOADER_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0]           tcnt;
`endif

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state        <= S_IDLE;
      byte_cnt     <= '0;
      shreg        <= '0;
      word_idx     <= '0;
      o_we         <= 1'b0;
      o_addr       <= '0;
      o_wdata      <= '0;
      o_busy       <= 1'b0;
      o_done       <= 1'b0;
      o_error      <= 1'b0;
      o_word_count <= '0;
`ifdef INSTR_LOADER_TIMEOUT_EN
      tcnt         <= '0;
`endif
    end else begin
      o_we <= 1'b0;
      unique case (state)
        S_IDLE, S_DONE, S_ERROR: begin
          // a byte arriving with the start is dropped
          if (i_start) begin
            state        <= S_RECV;
            byte_cnt     <= '0;
            word_idx     <= '0;
            o_word_count <= '0;
            o_done       <= 1'b0;
            o_error      <= 1'b0;
            o_busy       <= 1'b1;
`ifdef INSTR_LOADER_TIMEOUT_EN
            tcnt         <= '0;
`endif
          end
        end
        S_RECV: begin
          if (i_rx_valid) begin
`ifdef INSTR_LOADER_TIMEOUT_EN
            tcnt <= '0;
`endif
            if (byte_cnt == 2'd3) begin
              o_wdata  <= {shreg, i_rx_data};
              o_addr   <= ADDR_WIDTH'({word_idx, 2'b00});
              o_we     <= 1'b1;
              byte_cnt <= '0;
              state    <= S_WRITE;
            end else begin
              shreg    <= {shreg[DATA_WIDTH-17:0], i_rx_data};
              byte_cnt <= byte_cnt + 2'd1;
            end
          end
`ifdef INSTR_LOADER_TIMEOUT_EN
          else if (tcnt == TW'(TIMEOUT_CYCLES - 1)) begin
            state    <= S_ERROR;
            o_error  <= 1'b1;
            o_busy   <= 1'b0;
            byte_cnt <= '0;
          end else begin
            tcnt <= tcnt + TW'(1);
          end
`endif
        end
        S_WRITE: begin
          o_word_count <= o_word_count + CW'(1);
          if (o_wdata == HALT_WORD) begin
            state  <= S_DONE;
            o_done <= 1'b1;
            o_busy <= 1'b0;
          end else if (word_idx == IW'(MEM_DEPTH - 1)) begin
            state   <= S_ERROR;
            o_error <= 1'b1;
            o_busy  <= 1'b0;
          end else begin
            word_idx <= word_idx + IW'(1);
            state    <= S_RECV;
`ifdef INSTR_LOADER_TIMEOUT_EN
            tcnt     <= '0;
`endif
            // byte in the write cycle starts the next word
            if (i_rx_valid) begin
              shreg    <= {shreg[DATA_WIDTH-17:0], i_rx_data};
              byte_cnt <= 2'd1;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_instr_mem_loader.sv
// Randomized scoreboard bench for instr_mem_loader.
// Model groups bytes into words; monitor compares each imem write.
module tb_instr_mem_loader;

  localparam int DEPTH = 4;
  localparam logic [31:0] HALT = 32'hFFFFFFFF;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        we;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        busy;
  logic        done;
  logic        error;
  logic [2:0]  word_count;

  instr_mem_loader #(
    .MEM_DEPTH(DEPTH),
    .TIMEOUT_CYCLES(100)
  ) dut (
    .i_clk(clk),
    .i_reset_n(rst_n),
    .i_start(start),
    .i_rx_data(rx_data),
    .i_rx_valid(rx_valid),
    .o_we(we),
    .o_addr(addr),
    .o_wdata(wdata),
    .o_busy(busy),
    .o_done(done),
    .o_error(error),
    .o_word_count(word_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int passes = 0;

  typedef struct {
    logic [31:0] a;
    logic [31:0] d;
  } wr_t;

  wr_t exp_q[$];

  bit         m_active = 0;
  bit         m_done = 0;
  bit         m_err = 0;
  int         m_words = 0;
  logic [7:0] m_bytes[$];

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  function automatic void model_start();
    m_active = 1;
    m_done = 0;
    m_err = 0;
    m_words = 0;
    m_bytes.delete();
  endfunction

  function automatic void model_byte(logic [7:0] b);
    logic [31:0] w;
    wr_t e;
    if (!m_active) return;
    m_bytes.push_back(b);
    if (m_bytes.size() == 4) begin
      w = 32'(m_bytes[0]) * 32'h0100_0000 + 32'(m_bytes[1]) * 32'h1_0000
        + 32'(m_bytes[2]) * 32'h100 + 32'(m_bytes[3]);
      e.a = 32'(m_words * 4);
      e.d = w;
      exp_q.push_back(e);
      m_words++;
      m_bytes.delete();
      if (w == HALT) begin
        m_active = 0;
        m_done = 1;
      end else if (m_words == DEPTH) begin
        m_active = 0;
        m_err = 1;
      end
    end
  endfunction

  // one clock of stimulus; inputs held for that cycle
  task automatic step(bit v, logic [7:0] b, bit st);
    start = st;
    rx_valid = v;
    rx_data = b;
    if (st && !m_active) model_start();
    else if (v) model_byte(b);
    @(posedge clk);
    #1;
    start = 1'b0;
    rx_valid = 1'b0;
  endtask

  task automatic send_word(logic [31:0] w);
    for (int i = 3; i >= 0; i--) step(1'b1, w[i*8 +: 8], 1'b0);
  endtask

  task automatic check_status(string tag);
    step(1'b0, 8'h00, 1'b0);
    step(1'b0, 8'h00, 1'b0);
    check({tag, "_done"}, 32'(done), 32'(m_done));
    check({tag, "_error"}, 32'(error), 32'(m_err));
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_count"}, 32'(word_count), 32'(m_words));
    check({tag, "_pending"}, exp_q.size(), 32'd0);
  endtask

  task automatic check_reset_vals(string tag);
    check({tag, "_we"}, 32'(we), 32'd0);
    check({tag, "_addr"}, addr, 32'd0);
    check({tag, "_wdata"}, wdata, 32'd0);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_done"}, 32'(done), 32'd0);
    check({tag, "_error"}, 32'(error), 32'd0);
    check({tag, "_count"}, 32'(word_count), 32'd0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    m_active = 0;
    m_done = 0;
    m_err = 0;
    m_words = 0;
    m_bytes.delete();
    #2;
    check_reset_vals("reset");
    exp_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (rst_n && we) begin
      if (exp_q.size() == 0) begin
        checks++;
        $display("FAIL unexpected_write: addr %h data %h, no write expected", addr, wdata);
      end else begin
        wr_t e;
        e = exp_q.pop_front();
        check("wr_addr", addr, e.a);
        check("wr_data", wdata, e.d);
        check("wr_busy", 32'(busy), 32'd1);
      end
    end
  end

  initial begin
    logic [31:0] w;
    logic [7:0]  pend[$];
    bit          st;
    rst_n = 1'b0;
    start = 1'b0;
    rx_valid = 1'b0;
    rx_data = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    check_reset_vals("por");
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // first word, latency, then back-to-back words ending with HALT
    step(1'b0, 8'h00, 1'b1);
    step(1'b1, 8'h20, 1'b0);
    step(1'b1, 8'h08, 1'b0);
    step(1'b1, 8'h00, 1'b0);
    step(1'b1, 8'h05, 1'b0);
    check("first_we", 32'(we), 32'd1);
    step(1'b0, 8'h00, 1'b0);
    check("first_count", 32'(word_count), 32'd1);
    send_word(32'h1234_5678);
    send_word(32'h9ABC_DEF0);
    send_word(HALT);
    step(1'b1, 8'h77, 1'b0);
    check_status("halt");
    step(1'b1, 8'h11, 1'b0);
    check("halt_idle_busy", 32'(busy), 32'd0);

    // overflow: DEPTH non-HALT words
    step(1'b1, 8'hAB, 1'b1);
    for (int i = 0; i < DEPTH; i++) send_word(32'h0100_0000 * 32'(i + 1) + 32'h33);
    check_status("ovf");

    // reset mid-word, then fresh load at address 0
    step(1'b0, 8'h00, 1'b1);
    step(1'b1, 8'hDE, 1'b0);
    step(1'b1, 8'hAD, 1'b0);
    do_reset();
    step(1'b0, 8'h00, 1'b1);
    send_word(32'hCAFE_0001);
    send_word(HALT);
    check_status("after_rst");

    // idle mid-word
    step(1'b0, 8'h00, 1'b1);
    step(1'b1, 8'h01, 1'b0);
    step(1'b1, 8'h02, 1'b0);
    repeat (1000) step(1'b0, 8'h00, 1'b0);
`ifdef INSTR_LOADER_TIMEOUT_EN
    check("timeout_error", 32'(error), 32'd1);
    check("timeout_busy", 32'(busy), 32'd0);
`else
    check("no_timeout_error", 32'(error), 32'd0);
    check("no_timeout_busy", 32'(busy), 32'd1);
`endif
    check("timeout_count", 32'(word_count), 32'd0);
    do_reset();

    // randomized loads
    for (int n = 0; n < 25; n++) begin
      step(1'b1, 8'($urandom), 1'b1);
      pend.delete();
      while (m_active) begin
        if (pend.size() == 0) begin
          w = ($urandom_range(0, 4) == 0) ? HALT : $urandom;
          for (int i = 3; i >= 0; i--) pend.push_back(w[i*8 +: 8]);
        end
        if ($urandom_range(0, 3) == 0) step(1'b0, 8'h00, 1'b0);
        st = ($urandom_range(0, 7) == 0);
        step(1'b1, pend.pop_front(), st);
      end
      step(1'b1, 8'($urandom), 1'b0);
      check_status("rand");
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
